// File: rtl/apb_bridge_ctrl.sv
// -----------------------------------------------------------------------------
// apb_bridge_ctrl
//
// Sequencing controller for the APB side of an AHB-Lite to APB bridge.
// It accepts AHB-Lite single transfers and decodes which of three peripheral
// slots is the target. It then runs the two-phase APB SETUP/ACCESS sequence and
// holds the AHB master in its data phase until the APB access completes.
//
// Handshake: the AHB side uses HREADYin/HREADYOUT as its valid/ready pair.
// An address phase is taken only in a cycle where HSEL, HREADYin and a
// NONSEQ/SEQ HTRANS are all high and the address decodes to a slot. The data
// phase completes in the first cycle where HREADYOUT is high. While HREADYOUT
// is low, the address/control inputs are ignored. On the APB side,
// PSELx/PENABLE follow the standard SETUP (PSELx=1, PENABLE=0) then ACCESS
// (PSELx=1, PENABLE=1) order. Slaves are assumed zero-wait (no PREADY).
//
// Parameters:
//   ADDR_BASE  base address of peripheral slot 0
//   SLOT_BITS  log2 of each slot's size; slot k = ADDR_BASE + k*2^SLOT_BITS
//
// Ports:
//   HCLK, HRESET      clock, asynchronous active-high reset
//   HSEL, HREADYin    AHB select and bus ready
//   HTRANS, HWRITE    AHB transfer type and direction
//   HADDR, HWDATA     AHB address and write data
//   PRDATA            APB read data
//   HREADYOUT, HRESP  AHB ready (low = wait state) and response (always OKAY)
//   HRDATA            AHB read data (pass-through of PRDATA during read ACCESS)
//   PSELx             one-hot APB peripheral select
//   PENABLE, PWRITE   APB access phase and direction
//   PADDR, PWDATA     APB address and write data
// -----------------------------------------------------------------------------
module apb_bridge_ctrl #(
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter int          SLOT_BITS = 26
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic        HREADYin,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [31:0] PRDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA,
    output logic [2:0]  PSELx,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA
);

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [31:0] NUM_SLOTS    = 32'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WWAIT   = 3'd1,
        ST_READ    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RENABLE = 3'd4,
        ST_WENABLE = 3'd5
    } state_t;

    state_t state;
    state_t next_state;

    // ---------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------
    logic [31:0] slot_offset;
    logic [31:0] slot_num;
    logic [1:0]  slot_idx;
    logic        in_range;
    logic        valid_xfer;
    logic        can_accept;
    logic        accept;

    // The subtraction wraps for addresses below ADDR_BASE, so they produce a
    // huge slot number and fail the range check without a separate compare.
    assign slot_offset = HADDR - ADDR_BASE;
    assign slot_num    = slot_offset >> SLOT_BITS;
    assign in_range    = (slot_num < NUM_SLOTS);
    assign slot_idx    = slot_num[1:0];

    assign valid_xfer  = HSEL && HREADYin && in_range &&
                         ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    // A new address phase can only be taken when the previous data phase is
    // finishing, which is exactly when HREADYOUT is high: IDLE and the ACCESS states.
    assign can_accept  = (state == ST_IDLE) || (state == ST_RENABLE) ||
                         (state == ST_WENABLE);
    assign accept      = valid_xfer && can_accept;

    // ---------------------------------------------------------------------
    // Latched transfer (address, direction, slot)
    // ---------------------------------------------------------------------
    logic [31:0] addr_q;
    logic        write_q;
    logic [1:0]  slot_q;

    // Values that the upcoming SETUP/ACCESS cycle should present: a transfer
    // accepted this cycle wins over the one already held.
    logic [31:0] addr_next;
    logic        write_next;
    logic [1:0]  slot_next;

    assign addr_next  = accept ? HADDR    : addr_q;
    assign write_next = accept ? HWRITE   : write_q;
    assign slot_next  = accept ? slot_idx : slot_q;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            slot_q  <= '0;
        end else if (accept) begin
            addr_q  <= HADDR;
            write_q <= HWRITE;
            slot_q  <= slot_idx;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and next values of the registered outputs
    // ---------------------------------------------------------------------
    logic       hready_nx;
    logic [2:0] psel_nx;
    logic       penable_nx;
    logic       load_apb;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (valid_xfer) begin
                    next_state = HWRITE ? ST_WWAIT : ST_READ;
                end
            end
            ST_WWAIT:   next_state = ST_WRITE;
            ST_READ:    next_state = ST_RENABLE;
            ST_WRITE:   next_state = ST_WENABLE;
            ST_RENABLE,
            ST_WENABLE: begin
                // Back-to-back: the master has already advanced to its next
                // address phase, so go straight into the next transfer.
                if (valid_xfer) begin
                    next_state = HWRITE ? ST_WWAIT : ST_READ;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default:    next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being
    // entered rather than the current one.
    always_comb begin
        hready_nx  = 1'b1;
        psel_nx    = 3'b000;
        penable_nx = 1'b0;
        load_apb   = 1'b0;
        case (next_state)
            ST_WWAIT: begin
                hready_nx = 1'b0;
            end
            ST_READ,
            ST_WRITE: begin
                hready_nx = 1'b0;
                psel_nx   = 3'b001 << slot_next;
                load_apb  = 1'b1;
            end
            ST_RENABLE,
            ST_WENABLE: begin
                psel_nx    = 3'b001 << slot_next;
                penable_nx = 1'b1;
            end
            default: begin
                hready_nx = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HREADYOUT <= 1'b1;
            PSELx     <= 3'b000;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
        end else begin
            HREADYOUT <= hready_nx;
            PSELx     <= psel_nx;
            PENABLE   <= penable_nx;
            // PADDR/PWRITE change only on entry to SETUP, so they stay stable
            // through ACCESS and keep their last values while idle.
            if (load_apb) begin
                PADDR  <= addr_next;
                PWRITE <= write_next;
            end
            // HWDATA is valid during the write data phase, i.e. in ST_WWAIT.
            if (state == ST_WWAIT) begin
                PWDATA <= HWDATA;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Combinational AHB return path
    // ---------------------------------------------------------------------
    assign HRDATA = (state == ST_RENABLE) ? PRDATA : 32'h0000_0000;
    assign HRESP  = 2'b00;

    // ---------------------------------------------------------------------
    // Protocol properties
    // ---------------------------------------------------------------------
    a_psel_onehot0 : assert property (@(posedge HCLK) disable iff (HRESET)
        $onehot0(PSELx));

    a_penable_after_setup : assert property (@(posedge HCLK) disable iff (HRESET)
        PENABLE |-> (($past(PSELx) != 3'b000) && ($past(PSELx) == PSELx) &&
                     ($past(PADDR) == PADDR)));

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_bridge_ctrl
//
// Directed and random stimulus for apb_bridge_ctrl. Inputs are driven 1 time
// unit after the rising edge and outputs are sampled on the falling edge.
// The reference model describes each accepted AHB transfer as the list of
// data-phase cycles it must produce: a read gives SETUP then ACCESS, and a
// write gives a data wait, then SETUP, then ACCESS. Cycles with no transfer
// pending are idle.
// -----------------------------------------------------------------------------
module tb_apb_bridge_ctrl;

    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam logic [31:0] SLOT_SIZE = 32'h0400_0000;
    // APB slave stub returns PADDR ^ KEY on a read access; chosen so that
    // 32'h8400_0010 reads back as 32'h0000_1111.
    localparam logic [31:0] KEY       = 32'h8400_1101;

    localparam int K_IDLE   = 0;
    localparam int K_WWAIT  = 1;
    localparam int K_ACTIVE = 2;

    // ---------------- clock / reset ----------------
    logic        HCLK;
    logic        HRESET;
    logic        HSEL;
    logic        HREADYin;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] PRDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;
    logic [2:0]  PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    apb_bridge_ctrl dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HREADYin  (HREADYin),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .PRDATA    (PRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA)
    );

    // APB slave stub: valid data only during a read access, junk otherwise.
    assign PRDATA = (PENABLE && !PWRITE) ? (PADDR ^ KEY) : ~(PADDR ^ KEY);

    // ---------------- reference model ----------------
    typedef struct {
        int          kind;
        logic        rdy;
        logic [2:0]  psel;
        logic        pen;
        logic        pwr;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [31:0] hrdata;
    } cyc_t;

    cyc_t        exp_q[$];
    logic [31:0] last_paddr;
    logic        last_pwr;
    logic [31:0] last_pwdata;
    logic        pend_w;
    logic [31:0] pend_wdata;

    int total;
    int bad;

    function automatic cyc_t mk(input int kind, input logic rdy, input logic [2:0] psel,
                                input logic pen, input logic pwr, input logic [31:0] paddr,
                                input logic [31:0] pwdata, input logic [31:0] hrdata);
        cyc_t c;
        c.kind   = kind;
        c.rdy    = rdy;
        c.psel   = psel;
        c.pen    = pen;
        c.pwr    = pwr;
        c.paddr  = paddr;
        c.pwdata = pwdata;
        c.hrdata = hrdata;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_paddr  = 32'h0;
        last_pwr    = 1'b0;
        last_pwdata = 32'h0;
        pend_w      = 1'b0;
        pend_wdata  = 32'h0;
    endtask

    // ---------------- driver: one bus cycle ----------------
    // Called 1 unit after a rising edge; returns 1 unit after the next one.
    task automatic cyc(input logic s, input logic r, input logic [1:0] t, input logic w,
                       input logic [31:0] a, input logic [31:0] wd);
        cyc_t        cur;
        logic [31:0] off;
        logic [31:0] slot;
        logic [2:0]  oh;
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else                  cur = mk(K_IDLE, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

        HSEL     = s;
        HREADYin = r;
        HTRANS   = t;
        HWRITE   = w;
        HADDR    = a;
        HWDATA   = pend_w ? pend_wdata : $urandom();
        pend_w   = 1'b0;

        @(negedge HCLK);
        chk("hreadyout", 32'(HREADYOUT), 32'(cur.rdy));
        chk("psel",      32'(PSELx),     32'(cur.psel));
        chk("penable",   32'(PENABLE),   32'(cur.pen));
        chk("hrdata",    HRDATA,         cur.hrdata);
        chk("hresp",     32'(HRESP),     32'h0);
        if (cur.kind == K_IDLE) begin
            chk("paddr_hold",  PADDR,       last_paddr);
            chk("pwrite_hold", 32'(PWRITE), 32'(last_pwr));
            chk("pwdata_hold", PWDATA,      last_pwdata);
        end else if (cur.kind == K_WWAIT) begin
            chk("pwdata_wwait", PWDATA, last_pwdata);
        end else begin
            chk("paddr",  PADDR,       cur.paddr);
            chk("pwrite", 32'(PWRITE), 32'(cur.pwr));
            chk("pwdata", PWDATA,      cur.pwr ? cur.pwdata : last_pwdata);
            last_paddr = cur.paddr;
            last_pwr   = cur.pwr;
            if (cur.pwr) last_pwdata = cur.pwdata;
        end

        // Acceptance: only when the bridge is ready and the address falls in
        // one of the three slots.
        off  = a - BASE;
        slot = off / SLOT_SIZE;
        if (cur.rdy && s && r && t[1] && (slot < 32'd3)) begin
            oh = (slot == 32'd0) ? 3'b001 : (slot == 32'd1) ? 3'b010 : 3'b100;
            if (w) begin
                exp_q.push_back(mk(K_WWAIT,  1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0));
                exp_q.push_back(mk(K_ACTIVE, 1'b0, oh,     1'b0, 1'b1, a,     wd,    32'h0));
                exp_q.push_back(mk(K_ACTIVE, 1'b1, oh,     1'b1, 1'b1, a,     wd,    32'h0));
                pend_w     = 1'b1;
                pend_wdata = wd;
            end else begin
                exp_q.push_back(mk(K_ACTIVE, 1'b0, oh, 1'b0, 1'b0, a, 32'h0, 32'h0));
                exp_q.push_back(mk(K_ACTIVE, 1'b1, oh, 1'b1, 1'b0, a, 32'h0, a ^ KEY));
            end
        end

        @(posedge HCLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 2'b00, 1'b0, $urandom(), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total    = 0;
        bad      = 0;
        HRESET   = 1'b0;
        HSEL     = 1'b0;
        HREADYin = 1'b1;
        HTRANS   = 2'b00;
        HWRITE   = 1'b0;
        HADDR    = 32'h0;
        HWDATA   = 32'h0;
        model_reset();

        // Reset values.
        #1 HRESET = 1'b1;
        #1;
        chk("rst_hreadyout", 32'(HREADYOUT), 32'h1);
        chk("rst_psel",      32'(PSELx),     32'h0);
        chk("rst_penable",   32'(PENABLE),   32'h0);
        chk("rst_pwrite",    32'(PWRITE),    32'h0);
        chk("rst_paddr",     PADDR,          32'h0);
        chk("rst_pwdata",    PWDATA,         32'h0);
        chk("rst_hrdata",    HRDATA,         32'h0);
        chk("rst_hresp",     32'(HRESP),     32'h0);
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        idle(2);

        // Read from slot 1: expect 32'h0000_1111 in the ACCESS cycle.
        cyc(1'b1, 1'b1, 2'b10, 1'b0, 32'h8400_0010, 32'h0);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, $urandom(), 32'h0);
        cyc(1'b0, 1'b1, 2'b00, 1'b0, $urandom(), 32'h0);
        idle(1);

        // Write to slot 2.
        cyc(1'b1, 1'b1, 2'b10, 1'b1, 32'h8800_0004, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, $urandom(), 32'h0);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, $urandom(), 32'h0);
        cyc(1'b0, 1'b1, 2'b00, 1'b0, $urandom(), 32'h0);
        idle(1);

        // Back-to-back: read, then SEQ write presented during read ACCESS.
        cyc(1'b1, 1'b1, 2'b10, 1'b0, 32'h8000_0000, 32'h0);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, $urandom(), 32'h0);
        cyc(1'b1, 1'b1, 2'b11, 1'b1, 32'h8000_0004, 32'h1234_5678);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, $urandom(), 32'h0);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, $urandom(), 32'h0);
        cyc(1'b0, 1'b1, 2'b00, 1'b0, $urandom(), 32'h0);
        idle(1);

        // Ignored transfers: out of range, BUSY, below base, HREADYin low, HSEL low.
        cyc(1'b1, 1'b1, 2'b10, 1'b0, 32'h8C00_0000, 32'h0);
        cyc(1'b1, 1'b1, 2'b01, 1'b0, 32'h8000_0100, 32'h0);
        cyc(1'b1, 1'b1, 2'b10, 1'b1, 32'h7FFF_FFFC, 32'h0);
        cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0008, 32'h0);
        cyc(1'b0, 1'b1, 2'b10, 1'b0, 32'h8400_0008, 32'h0);
        idle(1);

        // Last word of slot 2 is still in range.
        cyc(1'b1, 1'b1, 2'b10, 1'b0, 32'h8BFF_FFFC, 32'h0);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, $urandom(), 32'h0);
        cyc(1'b0, 1'b1, 2'b00, 1'b0, $urandom(), 32'h0);
        idle(1);

        // Valid-looking address changes during wait states must be ignored.
        cyc(1'b1, 1'b1, 2'b10, 1'b1, 32'h8000_0040, 32'hCAFE_F00D);
        cyc(1'b1, 1'b1, 2'b10, 1'b0, 32'h8400_0000, 32'h0);
        cyc(1'b1, 1'b1, 2'b11, 1'b0, 32'h8800_0000, 32'h0);
        cyc(1'b0, 1'b1, 2'b00, 1'b0, $urandom(), 32'h0);
        idle(1);

        // Reset asserted during write ACCESS aborts immediately.
        cyc(1'b1, 1'b1, 2'b10, 1'b1, 32'h8400_0020, 32'h5555_AAAA);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, $urandom(), 32'h0);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, $urandom(), 32'h0);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        chk("pre_rst_penable", 32'(PENABLE), 32'h1);
        #1 HRESET = 1'b1;
        #1;
        chk("mid_rst_psel",      32'(PSELx),     32'h0);
        chk("mid_rst_penable",   32'(PENABLE),   32'h0);
        chk("mid_rst_hreadyout", 32'(HREADYOUT), 32'h1);
        chk("mid_rst_paddr",     PADDR,          32'h0);
        model_reset();
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        idle(2);
        cyc(1'b1, 1'b1, 2'b10, 1'b0, 32'h8000_0010, 32'h0);
        cyc(1'b0, 1'b0, 2'b00, 1'b0, $urandom(), 32'h0);
        cyc(1'b0, 1'b1, 2'b00, 1'b0, $urandom(), 32'h0);
        idle(1);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            logic [31:0] a;
            int          pick;
            pick = $urandom_range(0, 4);
            if (pick <= 3) a = BASE + (32'(pick) * SLOT_SIZE) + ($urandom() & 32'h03FF_FFFC);
            else           a = $urandom();
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom());
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_bridge_ctrl.md
Name: apb_bridge_ctrl

Overview:
- Sequencing controller for the APB side of the AHB-to-APB bridge.
- Accepts AHB-Lite single transfers and decodes the target peripheral.
- Generates the two-phase APB SETUP/ACCESS sequence on PSELx/PENABLE/PWRITE/PADDR/PWDATA, which feed the APB pin interface.
- Returns PRDATA to the AHB side and stalls the AHB master with HREADYOUT until the APB access phase completes.

Parameters:
- ADDR_BASE, 32'h8000_0000, base address of peripheral slot 0.
- SLOT_BITS, 26, log2 of each slot's size; slot k = ADDR_BASE + k*2^SLOT_BITS, k = 0..2.

Ports:
- HCLK  input  1  bridge clock; all state on rising edge.
- HRESET  input  1  asynchronous, active-high reset.
- HSEL  input  1  bridge selected by the AHB decoder.
- HREADYin  input  1  AHB bus ready; a transfer is sampled only when high.
- HTRANS  input  2  AHB transfer type; 2'b10 NONSEQ and 2'b11 SEQ are valid, IDLE/BUSY are ignored.
- HWRITE  input  1  AHB direction; 1 = write.
- HADDR  input  32  AHB address.
- HWDATA  input  32  AHB write data, valid in the data phase.
- PRDATA  input  32  read data from the APB side.
- HREADYOUT  output  1  bridge ready; low stalls the AHB data phase.
- HRESP  output  2  tied to 2'b00 (OKAY).
- HRDATA  output  32  read data to AHB.
- PSELx  output  3  one-hot peripheral select.
- PENABLE  output  1  APB access phase.
- PWRITE  output  1  APB direction.
- PADDR  output  32  APB address.
- PWDATA  output  32  APB write data.

Behaviour:
- valid = HSEL & HREADYin & HTRANS[1] & in-range.
- in-range: (HADDR - ADDR_BASE) >> SLOT_BITS is 0, 1 or 2; slot index k selects PSELx = 1<<k.
- Out-of-range or non-valid transfers are ignored: zero-wait OKAY, no APB activity.
- Reset (async, immediate) values:
  - state = ST_IDLE.
  - PSELx = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0.
  - HREADYOUT = 1, HRDATA = 0, HRESP = 0.
- Reset mid-transfer aborts the APB cycle with no completion.
- FSM states and transitions:
  - ST_IDLE: HREADYOUT = 1, PSELx = 0. If valid: latch HADDR, HWRITE and slot; go to ST_READ if read, ST_WWAIT if write.
  - ST_WWAIT: write data phase. HREADYOUT = 0, PSELx = 0. Capture HWDATA into PWDATA at the clock edge; go to ST_WRITE.
  - ST_READ / ST_WRITE (SETUP): PSELx = latched one-hot, PENABLE = 0, PADDR = latched address, PWRITE = 0 or 1. HREADYOUT = 0. Go to ST_RENABLE / ST_WENABLE.
  - ST_RENABLE / ST_WENABLE (ACCESS): PSELx held, PENABLE = 1, HREADYOUT = 1.
    - From ST_RENABLE: HRDATA = PRDATA (combinational pass-through); HRDATA = 0 in all other states.
    - Exit: if valid this cycle (back-to-back; the AHB master has advanced), latch the new transfer and go to ST_READ/ST_WWAIT. Otherwise go to ST_IDLE.
- Outputs are registered, except HRDATA and HRESP.
- PADDR, PWRITE and PWDATA hold their last values in ST_IDLE; only PSELx and PENABLE return to 0.
- Latency:
  - Read: 2 data-phase cycles (one wait state).
  - Write: 3 data-phase cycles (two wait states).
- PENABLE is never high unless PSELx was non-zero with the same address in the previous cycle.
- PSELx is never multi-hot.
- Address/control latched in ST_IDLE or an ACCESS state is unaffected by HADDR changes during wait states.

Test Plan:
- Reset: assert HRESET during ST_WENABLE -> PSELx = 0, PENABLE = 0, HREADYOUT = 1 in the same cycle; FSM restarts in ST_IDLE.
- Read from slot 1:
  - Stimulus: HADDR = 32'h8400_0010, HTRANS = 2'b10, HWRITE = 0; PRDATA stub returns 32'h0000_1111 when PENABLE & !PWRITE.
  - Response: SETUP cycle PSELx = 3'b010, PENABLE = 0, HREADYOUT = 0. Next cycle PENABLE = 1, HREADYOUT = 1, HRDATA = 32'h0000_1111.
- Write to slot 2:
  - Stimulus: HADDR = 32'h8800_0004, HWRITE = 1; HWDATA = 32'hDEAD_BEEF next cycle.
  - Response: ST_WWAIT with HREADYOUT = 0. Then SETUP with PSELx = 3'b100, PWRITE = 1, PWDATA = 32'hDEAD_BEEF. Then ACCESS with PENABLE = 1, HREADYOUT = 1. Total 3 data-phase cycles.
- Back-to-back:
  - Stimulus: read to 32'h8000_0000 followed by a SEQ write to 32'h8000_0004 presented during ST_RENABLE.
  - Response: no ST_IDLE between; PENABLE drops to 0 for exactly one cycle (ST_WWAIT) before the write SETUP.
- Ignored transfers:
  - HADDR = 32'h8C00_0000 with NONSEQ, or HTRANS = 2'b01 (BUSY) in range -> PSELx stays 0, HREADYOUT stays 1, HRESP = 2'b00.
- HREADYin = 0 with a valid in-range NONSEQ -> no transfer started.
